canvas_store: RTL
=================

// Module: canvas_store
// PURPOSE
//  Parametrised drawing-canvas framebuffer between the brush/command path and the VGA pixel pipeline.
//  Owns a CANVAS_W x CANVAS_H single-clock RAM of COLOR_W-bit codes, placed at (ORIGIN_X, ORIGIN_Y) on screen.
//  Adds square multi-pixel brush stamps, a full-canvas clear sweep, auto-clear after reset,
//  and a latency-aligned read path with border fill.
// PARAMETERS
//  CANVAS_W      180     canvas width in pixels (power of two not required)
//  CANVAS_H      180     canvas height in pixels
//  ORIGIN_X      230     screen x of canvas column 0
//  ORIGIN_Y      150     screen y of canvas row 0
//  COLOR_W       3       colour-code width
//  COORD_W       8       brush coordinate width; 2**COORD_W >= max(CANVAS_W, CANVAS_H)
//  BORDER_COLOR  3'b101  code output for screen pixels outside the canvas
//  CLEAR_COLOR   3'b000  code written by a clear sweep
// PORTS
//  clk          in   1        single system clock
//  reset        in   1        synchronous, active-low reset
//  brush        in   1        stamp request; accepted when brush && brush_ready
//  brush_size   in   3        stamp side minus one; s -> (s+1)x(s+1) square
//  newColor     in   COLOR_W  stamp colour
//  wx, wy       in   COORD_W  stamp top-left, canvas coordinates
//  clear        in   1        clear request; one-cycle pulse is sufficient
//  brush_ready  out  1        FSM idle and able to accept a stamp
//  busy         out  1        stamp or clear sweep in progress
//  rx, ry       in   10       screen coordinate being scanned
//  colorCode    out  COLOR_W  colour for (rx, ry); 1-cycle latency
// BEHAVIOUR
//  Address = y*CANVAS_W + x; depth = CANVAS_W*CANVAS_H; RAM is read-first on same-address read/write.
//  Reset (reset==0): state=CLEAR, sweep counter=0, pending-clear=0.
//    Outputs during reset: busy=1, brush_ready=0, colorCode=BORDER_COLOR.
//    Reset mid-stamp or mid-clear aborts the operation; the sweep restarts from address 0.
//  FSM states IDLE, STAMP, CLEAR.
//    IDLE:  brush_ready=1, busy=0.
//           If clear or pending-clear -> CLEAR (priority over brush).
//           Else if brush -> latch wx, wy, newColor, brush_size; dx=dy=0; -> STAMP.
//    STAMP: one candidate pixel per cycle, row-major.
//           Pixel = (wx+dx, wy+dy), computed at COORD_W+1 bits.
//           Written only if x<CANVAS_W && y<CANVAS_H. Clipped pixels still consume their cycle; no wrap-around.
//           Exactly (s+1)^2 cycles, then -> IDLE, or -> CLEAR if pending.
//           clear asserted during STAMP sets pending-clear; brush is ignored (ready=0).
//    CLEAR: writes CLEAR_COLOR to addresses 0..W*H-1, one per cycle (W*H cycles), then -> IDLE.
//           pending-clear is zeroed on CLEAR entry; clear and brush are ignored during CLEAR.
//  brush_ready = (state==IDLE) && reset; busy = (state!=IDLE).
//  Read path:
//    inwin = rx>=ORIGIN_X && rx<ORIGIN_X+CANVAS_W && ry>=ORIGIN_Y && ry<ORIGIN_Y+CANVAS_H.
//      Compared unsigned at 11 bits; no negative wrap.
//    RAM read address is formed from (rx-ORIGIN_X, ry-ORIGIN_Y) every cycle.
//    inwin is registered alongside the RAM output.
//    colorCode = inwin_q ? ram_q : BORDER_COLOR (registered; exactly 1 cycle after rx, ry).
//    Reads continue during STAMP and CLEAR, returning the current RAM contents.
// TESTING
//  Release reset -> busy=1 for exactly 32400 cycles; then brush_ready=1; rx=300, ry=200 gives colorCode=0.
//  Stamp wx=5, wy=7, newColor=3, size=0:
//    busy for 1 cycle; rx=235, ry=157 gives 3 one cycle later; (236,157) gives 0.
//  Stamp wx=178, wy=178, size=2, colour 6:
//    9 busy cycles; only (178..179, 178..179) read 6; (0,178) and (178,0) remain 0.
//  Border: (rx,ry) = (229,200), (410,200), (300,149), (300,330) -> colorCode=5; (230,150) -> canvas pixel (0,0).
//  clear pulse on cycle 2 of a size-3 stamp:
//    stamp completes all 16 cycles, then a 32400-cycle sweep; all pixels 0.
//    brush held high throughout is not accepted until the sweep ends.
//  reset low for 1 cycle mid-stamp:
//    brush_ready=0 and busy=1 during reset; a fresh full clear follows; the stamp is not resumed.

Source files
------------

// File: rtl/canvas_store_if.sv
// Brush/command and pixel-scan signals between the drawing logic and canvas_store.
interface canvas_store_if #(
  parameter int COLOR_W = 3,
  parameter int COORD_W = 8
);
  logic               brush;
  logic [2:0]         brush_size;
  logic [COLOR_W-1:0] newColor;
  logic [COORD_W-1:0] wx, wy;
  logic               clear;
  logic               brush_ready;
  logic               busy;
  logic [9:0]         rx, ry;
  logic [COLOR_W-1:0] colorCode;

  modport master (output brush, brush_size, newColor, wx, wy, clear, rx, ry,
                  input  brush_ready, busy, colorCode);
  modport slave  (input  brush, brush_size, newColor, wx, wy, clear, rx, ry,
                  output brush_ready, busy, colorCode);
endinterface

// File: rtl/canvas_store.sv
// Canvas framebuffer: square brush stamps, full clear sweep (also after reset),
// and a 1-cycle read path that fills BORDER_COLOR outside the canvas window.
module canvas_store #(
  parameter int                 CANVAS_W     = 180,
  parameter int                 CANVAS_H     = 180,
  parameter int                 ORIGIN_X     = 230,
  parameter int                 ORIGIN_Y     = 150,
  parameter int                 COLOR_W      = 3,
  parameter int                 COORD_W      = 8,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = 3'b101,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR  = 3'b000
) (
  input  logic          clk,
  input  logic          reset,
  canvas_store_if.slave bus
);
  localparam int DEPTH = CANVAS_W * CANVAS_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic [2:0]         size;
  } stamp_t;

  state_t             state, nstate;
  stamp_t             req, nreq;
  logic [2:0]         dx, dy, ndx, ndy;
  logic [AW-1:0]      cnt, ncnt;
  logic               pend, npend;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [COLOR_W-1:0] wdata;

  logic [COLOR_W-1:0] mem [DEPTH];
  logic [COLOR_W-1:0] ram_q;
  logic               inwin, inwin_q;
  logic [10:0]        rx11, ry11, cx, cy;
  logic [AW-1:0]      raddr;

  // Candidate stamp pixel, one bit wider so right/bottom overhang clips instead of wrapping.
  logic [SW-1:0] sx, sy;
  logic          inb;
  assign sx  = {1'b0, req.x} + SW'(dx);
  assign sy  = {1'b0, req.y} + SW'(dy);
  assign inb = (sx < SW'(CANVAS_W)) && (sy < SW'(CANVAS_H));

  // State register; reset aborts any operation and restarts the sweep at address 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
      pend  <= 1'b0;
      dx    <= '0;
      dy    <= '0;
      req   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      pend  <= npend;
      dx    <= ndx;
      dy    <= ndy;
      req   <= nreq;
    end
  end

  // Next-state and write-port control.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    npend  = pend;
    ndx    = dx;
    ndy    = dy;
    nreq   = req;
    we     = 1'b0;
    waddr  = AW'(sy) * AW'(CANVAS_W) + AW'(sx);
    wdata  = req.color;
    case (state)
      IDLE: begin
        if (bus.clear || pend) begin
          nstate = CLEAR;
          ncnt   = '0;
          npend  = 1'b0;
        end else if (bus.brush) begin
          nreq   = '{x: bus.wx, y: bus.wy, color: bus.newColor, size: bus.brush_size};
          ndx    = '0;
          ndy    = '0;
          nstate = STAMP;
        end
      end
      STAMP: begin
        we = inb;
        if (bus.clear) npend = 1'b1;
        if (dx == req.size) begin
          ndx = '0;
          if (dy == req.size) begin
            if (pend || bus.clear) begin
              nstate = CLEAR;
              ncnt   = '0;
              npend  = 1'b0;
            end else begin
              nstate = IDLE;
            end
          end else begin
            ndy = dy + 3'd1;
          end
        end else begin
          ndx = dx + 3'd1;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        wdata = CLEAR_COLOR;
        ncnt  = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) nstate = IDLE;
      end
      default: nstate = CLEAR;
    endcase
  end

  assign bus.brush_ready = (state == IDLE) && reset;
  assign bus.busy        = (state != IDLE) || !reset;

  // Window test at 11 bits so screen coordinates left/above the origin never wrap in.
  assign rx11  = {1'b0, bus.rx};
  assign ry11  = {1'b0, bus.ry};
  assign inwin = (rx11 >= 11'(ORIGIN_X)) && (rx11 < 11'(ORIGIN_X + CANVAS_W)) &&
                 (ry11 >= 11'(ORIGIN_Y)) && (ry11 < 11'(ORIGIN_Y + CANVAS_H));
  assign cx    = rx11 - 11'(ORIGIN_X);
  assign cy    = ry11 - 11'(ORIGIN_Y);
  assign raddr = inwin ? AW'(cy) * AW'(CANVAS_W) + AW'(cx) : '0;

  // Single-clock RAM, read-first on same-address collisions.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[raddr];
  end

  // Window flag travels with the RAM read so border fill lines up with the data.
  always_ff @(posedge clk) begin
    if (!reset) inwin_q <= 1'b0;
    else        inwin_q <= inwin;
  end

  assign bus.colorCode = inwin_q ? ram_q : BORDER_COLOR;
endmodule
